// File: rtl/core_issue_ctrl_pkg.sv
// Shared ISA opcode constants, sequencer state encodings and the opcode legality check
// used by the issue controller and its data-port arbiter.
package core_issue_ctrl_pkg;

  localparam logic [11:0] OP_MOVREG = 12'hE1A;
  localparam logic [11:0] OP_MOVNUM = 12'hE3A;
  localparam logic [11:0] OP_SVC    = 12'hEF0;
  localparam logic [11:0] OP_LDR    = 12'hE59;
  localparam logic [11:0] OP_SUBNUM = 12'hE24;
  localparam logic [11:0] OP_SUBREG = 12'hE04;
  localparam logic [11:0] OP_PUSH   = 12'hE52;
  localparam logic [11:0] OP_ADDNUM = 12'hE28;
  localparam logic [11:0] OP_ADDREG = 12'hE08;
  localparam logic [11:0] OP_POP    = 12'hE49;
  localparam logic [11:0] OP_ANDREG = 12'hE00;
  localparam logic [11:0] OP_ANDNUM = 12'hE20;
  localparam logic [11:0] OP_ORREG  = 12'hE18;
  localparam logic [11:0] OP_ORNUM  = 12'hE38;
  localparam logic [11:0] OP_STRREG = 12'hE78;
  localparam logic [11:0] OP_STRNUM = 12'hE58;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_READBACK,
    ST_DONE,
    ST_DBG
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_RB,
    OWN_DBG
  } owner_t;

  // Opcodes live in the low 12 bits; anything with upper bits set is illegal.
  function automatic logic is_legal_op(input logic [31:0] op);
    logic ok;
    ok = 1'b0;
    if (op[31:12] == 20'h0) begin
      case (op[11:0])
        OP_MOVREG, OP_MOVNUM, OP_SVC, OP_LDR, OP_SUBNUM, OP_SUBREG,
        OP_PUSH, OP_ADDNUM, OP_ADDREG, OP_POP, OP_ANDREG, OP_ANDNUM,
        OP_ORREG, OP_ORNUM, OP_STRREG, OP_STRNUM: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic op_is(input logic [31:0] op, input logic [11:0] code);
    return op == {20'h0, code};
  endfunction

endpackage

// File: rtl/core_issue_ctrl_port_arb.sv
// Core data-port owner: drives addr/data/wl/rdl for one access of RD_CYCLES cycles,
// either an LDR readback or a debug access, and captures core_dout at the end.
module core_port_arb
  import core_issue_ctrl_pkg::*;
#(
  parameter int RD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rb_go,
  input  logic [31:0] rb_addr,
  input  logic        dbg_go,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [31:0] core_dout,
  output logic [31:0] core_addr,
  output logic [31:0] core_data,
  output logic        core_wl,
  output logic        core_rdl,
  output logic        acc_last,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata,
  output logic [31:0] ldr_result
);

  localparam int CW = $clog2(RD_CYCLES) + 1;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);

  owner_t      owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        dbg_done_q, dbg_done_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic [31:0] ldr_result_q, ldr_result_d;

  assign acc_last = (owner_q != OWN_NONE) && (cnt_q == RD_LAST);

  always_comb begin
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    dbg_done_d   = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;
    ldr_result_d = ldr_result_q;
    if (owner_q != OWN_NONE) begin
      if (acc_last) begin
        owner_d = OWN_NONE;
        if (owner_q == OWN_RB) begin
          ldr_result_d = core_dout;
        end else begin
          dbg_done_d = 1'b1;
          if (!we_q) dbg_rdata_d = core_dout;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // The sequencer only issues a go while the port is free, so no preemption here.
    if (rb_go) begin
      owner_d = OWN_RB;
      we_d    = 1'b0;
      addr_d  = rb_addr;
      data_d  = 32'h0;
      cnt_d   = '0;
    end else if (dbg_go) begin
      owner_d = OWN_DBG;
      we_d    = dbg_we;
      addr_d  = dbg_addr;
      data_d  = dbg_wdata;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWN_NONE;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      data_q       <= 32'h0;
      cnt_q        <= '0;
      dbg_done_q   <= 1'b0;
      dbg_rdata_q  <= 32'h0;
      ldr_result_q <= 32'h0;
    end else begin
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      dbg_done_q   <= dbg_done_d;
      dbg_rdata_q  <= dbg_rdata_d;
      ldr_result_q <= ldr_result_d;
    end
  end

  assign core_wl    = (owner_q == OWN_DBG) && we_q;
  assign core_rdl   = (owner_q == OWN_RB) || ((owner_q == OWN_DBG) && !we_q);
  assign core_addr  = (owner_q != OWN_NONE) ? addr_q : 32'h0;
  assign core_data  = core_wl ? data_q : 32'h0;
  assign dbg_done   = dbg_done_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign ldr_result = ldr_result_q;

endmodule

// File: rtl/core_issue_ctrl.sv
// Program sequencer for the ARM7 core: fetches entries, holds them on the operand
// ports, performs LDR readback and shares the core data port with a debug master.
module core_issue_ctrl
  import core_issue_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int ISSUE_CYCLES = 2,
  parameter int RD_CYCLES    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  output logic              prog_req,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic              prog_ack,
  input  logic [127:0]      prog_data,
  output logic [31:0]       opcode,
  output logic [31:0]       oprand1,
  output logic [31:0]       oprand2,
  output logic [31:0]       oprand3,
  output logic [31:0]       core_addr,
  output logic [31:0]       core_data,
  output logic              core_wl,
  output logic              core_rdl,
  input  logic [31:0]       core_dout,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_done,
  output logic [31:0]       dbg_rdata,
  output logic [31:0]       ldr_result,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(ISSUE_CYCLES) + 1;
  localparam logic [CW-1:0] ISSUE_LAST = CW'(ISSUE_CYCLES - 1);

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [127:0]      entry_q, entry_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic              rb_go, dbg_go, goto_fetch, dbg_pending, acc_last;
  logic [31:0]       entry_op;

  assign entry_op = entry_q[127:96];
  // dbg_done is still high the cycle after an access while the requester drops its level.
  assign dbg_pending = dbg_req && !dbg_done;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    entry_d    = entry_q;
    wrap_d     = wrap_q;
    err_d      = err_q;
    rb_go      = 1'b0;
    dbg_go     = 1'b0;
    goto_fetch = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !halt) begin
          goto_fetch = 1'b1;
          pc_d       = '0;
          err_d      = 1'b0;
        end else if (dbg_pending) begin
          state_d = ST_DBG;
          ret_d   = state_q;
          dbg_go  = 1'b1;
        end
      end
      ST_FETCH: begin
        if (prog_ack) begin
          pc_d    = pc_q + 1'b1;
          entry_d = prog_data;
          wrap_d  = (pc_q == {ADDR_W{1'b1}});
          cnt_d   = '0;
          if (is_legal_op(prog_data[127:96])) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (cnt_q == ISSUE_LAST) begin
          if (op_is(entry_op, OP_LDR)) begin
            state_d = ST_READBACK;
            rb_go   = 1'b1;
          end else if (op_is(entry_op, OP_SVC)) begin
            state_d = ST_DONE;
          end else if (wrap_q) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (halt) begin
            state_d = ST_DONE;
          end else begin
            goto_fetch = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READBACK: begin
        if (acc_last) begin
          if (wrap_q) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (halt) begin
            state_d = ST_DONE;
          end else begin
            goto_fetch = 1'b1;
          end
        end
      end
      ST_DBG: begin
        if (acc_last) state_d = ret_q;
      end
      default: state_d = ST_IDLE;
    endcase
    // Debug may slip in only at fetch entry, before prog_req is raised.
    if (goto_fetch) begin
      if (dbg_pending) begin
        state_d = ST_DBG;
        ret_d   = ST_FETCH;
        dbg_go  = 1'b1;
      end else begin
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      entry_q <= 128'h0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  core_port_arb #(.RD_CYCLES(RD_CYCLES)) u_port_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rb_go      (rb_go),
    .rb_addr    ({entry_q[94:64], 1'b0}),
    .dbg_go     (dbg_go),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .core_dout  (core_dout),
    .core_addr  (core_addr),
    .core_data  (core_data),
    .core_wl    (core_wl),
    .core_rdl   (core_rdl),
    .acc_last   (acc_last),
    .dbg_done   (dbg_done),
    .dbg_rdata  (dbg_rdata),
    .ldr_result (ldr_result)
  );

  assign prog_req  = (state_q == ST_FETCH);
  assign prog_addr = pc_q;
  assign opcode    = (state_q == ST_ISSUE) ? entry_q[127:96] : 32'h0;
  assign oprand1   = (state_q == ST_ISSUE) ? entry_q[95:64]  : 32'h0;
  assign oprand2   = (state_q == ST_ISSUE) ? entry_q[63:32]  : 32'h0;
  assign oprand3   = (state_q == ST_ISSUE) ? entry_q[31:0]   : 32'h0;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                     (state_q == ST_READBACK) || ((state_q == ST_DBG) && (ret_q == ST_FETCH));
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed bench for core_issue_ctrl with a 4-entry program memory (ADDR_W=2)
// answering fetches on the falling edge.
module tb_core_issue_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         halt;
  logic         prog_req;
  logic [1:0]   prog_addr;
  logic         prog_ack;
  logic [127:0] prog_data;
  logic [31:0]  opcode, oprand1, oprand2, oprand3;
  logic [31:0]  core_addr, core_data;
  logic         core_wl, core_rdl;
  logic [31:0]  core_dout;
  logic         dbg_req, dbg_we;
  logic [31:0]  dbg_addr, dbg_wdata;
  logic         dbg_done;
  logic [31:0]  dbg_rdata, ldr_result;
  logic         busy, done, err;

  logic [127:0] mem [4];
  int checks;
  int errors;

  core_issue_ctrl #(.ADDR_W(2), .ISSUE_CYCLES(2), .RD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .prog_req(prog_req), .prog_addr(prog_addr), .prog_ack(prog_ack), .prog_data(prog_data),
    .opcode(opcode), .oprand1(oprand1), .oprand2(oprand2), .oprand3(oprand3),
    .core_addr(core_addr), .core_data(core_data), .core_wl(core_wl), .core_rdl(core_rdl),
    .core_dout(core_dout), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .ldr_result(ldr_result), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    prog_ack  = 1'b0;
    prog_data = 128'h0;
    forever begin
      @(negedge clk);
      prog_ack  = prog_req;
      prog_data = mem[prog_addr];
    end
  end

  function automatic logic [127:0] ent(input logic [11:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] c);
    return {20'h0, op, a, b, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_op();
    for (int k = 0; k < 30 && opcode === 32'h0; k++) tick();
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && done !== 1'b1; k++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (prog_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_prog_req got=%0h exp=0", prog_req); end
    checks++; if (opcode !== 32'h0) begin errors++; $display("[TB] FAIL reset_opcode got=%0h exp=0", opcode); end
    checks++; if ({core_wl, core_rdl} !== 2'b00) begin errors++; $display("[TB] FAIL reset_wl_rdl got=%0b exp=00", {core_wl, core_rdl}); end
    checks++; if ({busy, done, err, dbg_done} !== 4'h0) begin errors++; $display("[TB] FAIL reset_flags got=%0b exp=0000", {busy, done, err, dbg_done}); end
    checks++; if (ldr_result !== 32'h0) begin errors++; $display("[TB] FAIL reset_ldr_result got=%0h exp=0", ldr_result); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_program();
    logic [31:0] exp_op [4];
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    exp_op = '{32'hE3A, 32'hE78, 32'hE59, 32'hEF0};
    exp_a  = '{32'd1, 32'd1, 32'd0, 32'd0};
    exp_b  = '{32'd5, 32'd1, 32'd1, 32'd0};
    mem[0] = ent(12'hE3A, 1, 5, 0);
    mem[1] = ent(12'hE78, 1, 1, 1);
    mem[2] = ent(12'hE59, 0, 1, 1);
    mem[3] = ent(12'hEF0, 0, 0, 0);
    core_dout = 32'hCAFE_0001;
    pulse_start();
    checks++; if ({prog_req, busy, prog_addr} !== 4'b1100) begin errors++; $display("[TB] FAIL prog_first_fetch got=%0b exp=1100", {prog_req, busy, prog_addr}); end
    for (int i = 0; i < 4; i++) begin
      wait_op();
      checks++; if ({opcode, oprand1, oprand2} !== {exp_op[i], exp_a[i], exp_b[i]}) begin errors++; $display("[TB] FAIL prog_issue%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, opcode, oprand1, oprand2, exp_op[i], exp_a[i], exp_b[i]); end
      tick();
      checks++; if (opcode !== exp_op[i]) begin errors++; $display("[TB] FAIL prog_hold%0d got=%0h exp=%0h", i, opcode, exp_op[i]); end
      tick();
      checks++; if (opcode !== 32'h0) begin errors++; $display("[TB] FAIL prog_release%0d got=%0h exp=0", i, opcode); end
      if (i == 2) begin
        checks++; if ({core_rdl, core_wl, core_addr} !== {2'b10, 32'h0}) begin errors++; $display("[TB] FAIL ldr_rb_start got=%0b%0b/%0h exp=10/0", core_rdl, core_wl, core_addr); end
        tick();
        checks++; if (core_rdl !== 1'b1) begin errors++; $display("[TB] FAIL ldr_rb_hold got=%0b exp=1", core_rdl); end
        tick();
        checks++; if (core_rdl !== 1'b0) begin errors++; $display("[TB] FAIL ldr_rb_end got=%0b exp=0", core_rdl); end
        checks++; if (ldr_result !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL ldr_result got=%0h exp=cafe0001", ldr_result); end
      end
    end
    checks++; if ({done, err, busy} !== 3'b100) begin errors++; $display("[TB] FAIL prog_svc_done got=%0b exp=100", {done, err, busy}); end
  endtask

  task automatic test_dbg_during_issue();
    mem[0] = ent(12'hE28, 2, 3, 4);
    mem[1] = ent(12'hE1A, 1, 2, 0);
    mem[2] = ent(12'hEF0, 0, 0, 0);
    mem[3] = ent(12'hEF0, 0, 0, 0);
    core_dout = 32'h1234_5678;
    pulse_start();
    wait_op();
    dbg_we = 1'b0; dbg_addr = 32'h8; dbg_req = 1'b1;
    tick();
    checks++; if ({opcode, core_rdl} !== {32'hE28, 1'b0}) begin errors++; $display("[TB] FAIL dbg_waits got=%0h/%0b exp=e28/0", opcode, core_rdl); end
    tick();
    checks++; if ({core_rdl, core_addr, prog_req, busy} !== {1'b1, 32'h8, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL dbg_grant got=%0b/%0h/%0b/%0b exp=1/8/0/1", core_rdl, core_addr, prog_req, busy); end
    tick();
    checks++; if (core_rdl !== 1'b1) begin errors++; $display("[TB] FAIL dbg_hold got=%0b exp=1", core_rdl); end
    tick();
    checks++; if ({core_rdl, dbg_done} !== 2'b01) begin errors++; $display("[TB] FAIL dbg_done_pulse got=%0b exp=01", {core_rdl, dbg_done}); end
    checks++; if (dbg_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL dbg_rdata got=%0h exp=12345678", dbg_rdata); end
    checks++; if ({prog_req, prog_addr} !== 3'b101) begin errors++; $display("[TB] FAIL dbg_fetch_resume got=%0b exp=101", {prog_req, prog_addr}); end
    dbg_req = 1'b0;
    tick();
    checks++; if ({dbg_done, opcode} !== {1'b0, 32'hE1A}) begin errors++; $display("[TB] FAIL dbg_after got=%0b/%0h exp=0/e1a", dbg_done, opcode); end
    wait_done();
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("[TB] FAIL dbg_prog_done got=%0b exp=10", {done, err}); end
  endtask

  task automatic test_illegal();
    int issued;
    int saw_bad;
    issued = 0; saw_bad = 0;
    mem[0] = ent(12'hE3A, 1, 5, 0);
    mem[1] = ent(12'hE08, 1, 1, 1);
    mem[2] = {32'h0000_0ABC, 96'h0};
    mem[3] = ent(12'hEF0, 0, 0, 0);
    pulse_start();
    for (int k = 0; k < 60 && done !== 1'b1; k++) begin
      if (opcode !== 32'h0) issued++;
      if (opcode === 32'h0000_0ABC) saw_bad++;
      tick();
    end
    checks++; if (issued != 4) begin errors++; $display("[TB] FAIL illegal_issue_cycles got=%0d exp=4", issued); end
    checks++; if (saw_bad != 0) begin errors++; $display("[TB] FAIL illegal_issued got=%0d exp=0", saw_bad); end
    checks++; if ({done, err, busy} !== 3'b110) begin errors++; $display("[TB] FAIL illegal_done got=%0b exp=110", {done, err, busy}); end
  endtask

  task automatic test_halt();
    mem[0] = ent(12'hE28, 7, 8, 9);
    mem[1] = ent(12'hE3A, 1, 1, 0);
    mem[2] = ent(12'hE3A, 2, 2, 0);
    mem[3] = ent(12'hEF0, 0, 0, 0);
    pulse_start();
    checks++; if ({err, busy, done} !== 3'b010) begin errors++; $display("[TB] FAIL halt_restart got=%0b exp=010", {err, busy, done}); end
    wait_op();
    checks++; if (opcode !== 32'hE28) begin errors++; $display("[TB] FAIL halt_issue got=%0h exp=e28", opcode); end
    halt = 1'b1;
    tick();
    checks++; if (opcode !== 32'hE28) begin errors++; $display("[TB] FAIL halt_hold got=%0h exp=e28", opcode); end
    tick();
    checks++; if ({done, err, busy, opcode} !== {3'b100, 32'h0}) begin errors++; $display("[TB] FAIL halt_done got=%0b/%0h exp=100/0", {done, err, busy}, opcode); end
    pulse_start();
    checks++; if ({done, busy, prog_req} !== 3'b100) begin errors++; $display("[TB] FAIL halt_start_ignored got=%0b exp=100", {done, busy, prog_req}); end
    halt = 1'b0;
  endtask

  task automatic test_reset_readback();
    mem[0] = ent(12'hE59, 32'h10, 0, 0);
    mem[1] = ent(12'hEF0, 0, 0, 0);
    pulse_start();
    wait_op();
    tick();
    tick();
    checks++; if ({core_rdl, core_addr} !== {1'b1, 32'h20}) begin errors++; $display("[TB] FAIL rst_rb_addr got=%0b/%0h exp=1/20", core_rdl, core_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({core_rdl, busy, opcode, core_addr} !== {2'b00, 64'h0}) begin errors++; $display("[TB] FAIL rst_async got=%0b%0b/%0h/%0h exp=00/0/0", core_rdl, busy, opcode, core_addr); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++; if ({done, busy, prog_req} !== 3'b000) begin errors++; $display("[TB] FAIL rst_idle got=%0b exp=000", {done, busy, prog_req}); end
  endtask

  task automatic test_dbg_write();
    dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'hA5A5_0F0F; dbg_req = 1'b1;
    tick();
    checks++; if ({core_wl, core_rdl, busy} !== 3'b100) begin errors++; $display("[TB] FAIL dbgw_ctrl got=%0b exp=100", {core_wl, core_rdl, busy}); end
    checks++; if ({core_addr, core_data} !== {32'h44, 32'hA5A5_0F0F}) begin errors++; $display("[TB] FAIL dbgw_bus got=%0h/%0h exp=44/a5a50f0f", core_addr, core_data); end
    tick();
    checks++; if (core_wl !== 1'b1) begin errors++; $display("[TB] FAIL dbgw_hold got=%0b exp=1", core_wl); end
    tick();
    checks++; if ({core_wl, dbg_done, dbg_rdata} !== {2'b01, 32'h0}) begin errors++; $display("[TB] FAIL dbgw_end got=%0b%0b/%0h exp=01/0", core_wl, dbg_done, dbg_rdata); end
    dbg_req = 1'b0;
    tick();
    checks++; if ({dbg_done, core_wl} !== 2'b00) begin errors++; $display("[TB] FAIL dbgw_idle got=%0b exp=00", {dbg_done, core_wl}); end
  endtask

  task automatic test_wrap();
    int issued;
    issued = 0;
    mem[0] = ent(12'hE3A, 1, 1, 0);
    mem[1] = ent(12'hE28, 1, 1, 1);
    mem[2] = ent(12'hE24, 1, 1, 1);
    mem[3] = ent(12'hE38, 1, 1, 1);
    pulse_start();
    for (int k = 0; k < 60 && done !== 1'b1; k++) begin
      if (opcode !== 32'h0) issued++;
      tick();
    end
    checks++; if (issued != 8) begin errors++; $display("[TB] FAIL wrap_issue_cycles got=%0d exp=8", issued); end
    checks++; if ({done, err} !== 2'b11) begin errors++; $display("[TB] FAIL wrap_done got=%0b exp=11", {done, err}); end
    pulse_start();
    checks++; if ({prog_addr, err, busy, done} !== 5'b00010) begin errors++; $display("[TB] FAIL wrap_restart got=%0b exp=00010", {prog_addr, err, busy, done}); end
    wait_op();
    checks++; if (opcode !== 32'hE3A) begin errors++; $display("[TB] FAIL wrap_first_again got=%0h exp=e3a", opcode); end
    wait_done();
    checks++; if ({done, err} !== 2'b11) begin errors++; $display("[TB] FAIL wrap_done_again got=%0b exp=11", {done, err}); end
  endtask

  initial begin
    checks = 0; errors = 0;
    start = 1'b0; halt = 1'b0; core_dout = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    for (int i = 0; i < 4; i++) mem[i] = 128'h0;
    test_reset();
    test_program();
    test_dbg_during_issue();
    test_illegal();
    test_halt();
    test_reset_readback();
    test_dbg_write();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
